if_id_queue: RTL and testbench
==============================

IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter AddrSize, default 32, width of PC-related fields.
REQ-002 SHALL have parameter Inst_Size, default 32, width of instruction word.
REQ-003 SHALL have parameter NOP_INST, default 32'h00000013, word driven on out_inst when empty (addi x0,x0,0).
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have port in_valid  input  1  fetch presents a valid instruction.
REQ-007 SHALL have port in_inst  input  Inst_Size  fetched instruction word.
REQ-008 SHALL have port in_pc  input  AddrSize  address of fetched instruction.
REQ-009 SHALL have port in_pc_plus4  input  AddrSize  fetch-computed PC+4.
REQ-010 SHALL have port in_ready  output  1  queue accepts a word this cycle.
REQ-011 SHALL have port out_valid  output  1  head entry valid for decode.
REQ-012 SHALL have port out_inst  output  Inst_Size  head instruction, or NOP_INST when empty.
REQ-013 SHALL have port out_pc  output  AddrSize  head instruction address, 0 when empty.
REQ-014 SHALL have port out_pc_plus4  output  AddrSize  head PC+4, 0 when empty.
REQ-015 SHALL have port out_ready  input  1  decode consumes head this cycle.
REQ-016 SHALL have port flush  input  1  taken branch/jump redirect; discard all entries.
REQ-017 SHALL have port count  output  2  number of occupied entries (0..2).
REQ-018 SHALL have port bubble_cnt  output  16  saturating count of decode-starved cycles.

Function
REQ-019 SHALL store entries of {inst, pc, pc_plus4} in a 2-deep circular buffer with 1-bit write and read pointers and a 2-bit occupancy count.
REQ-020 SHALL drive in_ready = 1 iff count < 2; in_ready SHALL NOT depend combinationally on out_ready.
REQ-021 SHALL perform a push when in_valid && in_ready && !flush: write entry at wr_ptr, toggle wr_ptr.
REQ-022 SHALL perform a pop when out_valid && out_ready && !flush: toggle rd_ptr.
REQ-023 SHALL update count: +1 push only, -1 pop only, unchanged push-and-pop or neither.
REQ-024 SHALL drive out_valid = 1 iff count != 0; out_* fields SHALL come from entry at rd_ptr while valid.
REQ-025 SHALL present a pushed word on out_* no earlier than the cycle after the push (latency 1, no bypass).
REQ-026 SHALL, when empty, drive out_inst = NOP_INST, out_pc = 0, out_pc_plus4 = 0.
REQ-027 SHALL, when full (count = 2), hold in_ready = 0 even if out_ready = 1 in that cycle; pop proceeds, push is refused.
REQ-028 SHALL, when flush = 1, set count = 0 and both pointers = 0 next edge; same-cycle push and pop SHALL be ignored.
REQ-029 SHALL leave entry storage contents unchanged on flush (only occupancy cleared).
REQ-030 SHALL increment bubble_cnt by 1 on each cycle with out_ready = 1, out_valid = 0, flush = 0, saturating at 16'hFFFF.
REQ-031 SHALL NOT require in_* to be stable when in_valid = 0 or in_ready = 0.

Reset
REQ-032 SHALL, while reset = 0, asynchronously force count = 0, wr_ptr = 0, rd_ptr = 0, bubble_cnt = 0.
REQ-033 SHALL, in reset, drive out_valid = 0, in_ready = 1, out_inst = NOP_INST, out_pc = 0, out_pc_plus4 = 0, count = 0, bubble_cnt = 0.
REQ-034 SHALL discard all entries if reset asserts mid-operation; no entry survives deassertion.
REQ-035 SHALL resume normal push/pop on the first rising edge after reset returns to 1.

Verification
REQ-036 SHALL verify: reset release, push inst 32'h00500093 pc 0 pc_plus4 4 with out_ready=0 -> next cycle out_valid=1, out_inst=32'h00500093, out_pc_plus4=4, count=1.
REQ-037 SHALL verify: out_ready=0, push at pc 0, 4, 8 on consecutive cycles -> in_ready=0 on third cycle, count=2, pc 8 not stored; then out_ready=1 yields pc 0 then 4 in order.
REQ-038 SHALL verify: count=2, in_valid=1, out_ready=1 same cycle -> pop occurs, push refused, count=1 next cycle.
REQ-039 SHALL verify: count=2, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, out_inst=32'h00000013.
REQ-040 SHALL verify: continuous push and pop for 8 cycles at count=1 -> count stays 1, pointers wrap, FIFO order preserved, bubble_cnt unchanged.
REQ-041 SHALL verify: empty queue, out_ready=1 for 70000 cycles -> bubble_cnt = 16'hFFFF; reset=0 mid-stream -> all outputs return to REQ-033 values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/if_id_queue.sv
// ---------------------------------------------------------------------------
// if_id_queue
//   Two-entry elastic buffer between instruction fetch and decode. Each entry
//   carries {inst, pc, pc_plus4}. A pushed word becomes visible on out_* one
//   cycle after the push (there is no bypass path). A flush drops all
//   occupancy. A saturating counter records the cycles in which decode was
//   ready but had nothing to consume.
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous, active-low reset
//   in_valid      in   fetch presents a word
//   in_inst       in   fetched instruction
//   in_pc         in   address of fetched instruction
//   in_pc_plus4   in   fetch-computed PC+4
//   in_ready      out  queue can accept a word this cycle (count < 2)
//   out_valid     out  head entry valid for decode
//   out_inst      out  head instruction, NOP_INST when empty
//   out_pc        out  head address, 0 when empty
//   out_pc_plus4  out  head PC+4, 0 when empty
//   out_ready     in   decode consumes the head this cycle
//   flush         in   redirect; discard all entries
//   count         out  occupied entries (0..2)
//   bubble_cnt    out  saturating count of decode-starved cycles
// ---------------------------------------------------------------------------
module if_id_queue #(
    parameter int unsigned          AddrSize  = 32,
    parameter int unsigned          Inst_Size = 32,
    parameter logic [Inst_Size-1:0] NOP_INST  = Inst_Size'(32'h0000_0013)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [Inst_Size-1:0] in_inst,
    input  logic [AddrSize-1:0]  in_pc,
    input  logic [AddrSize-1:0]  in_pc_plus4,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [Inst_Size-1:0] out_inst,
    output logic [AddrSize-1:0]  out_pc,
    output logic [AddrSize-1:0]  out_pc_plus4,
    input  logic                 out_ready,
    input  logic                 flush,
    output logic [1:0]           count,
    output logic [15:0]          bubble_cnt
);

    localparam int unsigned Depth    = 2;
    localparam int unsigned CntW     = 2;
    localparam int unsigned BubbleW  = 16;
    localparam logic [CntW-1:0]    CntFull   = CntW'(Depth);
    localparam logic [BubbleW-1:0] BubbleMax = {BubbleW{1'b1}};

    typedef struct packed {
        logic [Inst_Size-1:0] inst;
        logic [AddrSize-1:0]  pc;
        logic [AddrSize-1:0]  pc_plus4;
    } entry_t;

    // Entry storage; deliberately not reset, occupancy alone defines validity.
    entry_t mem_q [Depth];

    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     count_q, count_d;
    logic [BubbleW-1:0]  bubble_q, bubble_d;

    logic   push_c;
    logic   pop_c;
    entry_t head_c;
    entry_t wr_entry_c;

    // Handshake status depends only on registered occupancy.
    assign in_ready  = (count_q < CntFull);
    assign out_valid = (count_q != '0);

    // Flush takes priority over both transfers in the same cycle.
    assign push_c = in_valid  && in_ready  && !flush;
    assign pop_c  = out_valid && out_ready && !flush;

    assign wr_entry_c = '{inst: in_inst, pc: in_pc, pc_plus4: in_pc_plus4};
    assign head_c     = mem_q[rd_ptr_q];

    // Head presentation; constant NOP/zero fields while empty.
    always_comb begin
        out_inst     = NOP_INST;
        out_pc       = '0;
        out_pc_plus4 = '0;
        if (out_valid) begin
            out_inst     = head_c.inst;
            out_pc       = head_c.pc;
            out_pc_plus4 = head_c.pc_plus4;
        end
    end

    assign count      = count_q;
    assign bubble_cnt = bubble_q;

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = '0;
        end else begin
            if (push_c) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop_c) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            unique case ({push_c, pop_c})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Starvation counter: decode ready, nothing to hand over, no redirect.
    always_comb begin
        bubble_d = bubble_q;
        if (out_ready && !out_valid && !flush && (bubble_q != BubbleMax)) begin
            bubble_d = bubble_q + BubbleW'(1);
        end
    end

    // Control state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
            bubble_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            bubble_q <= bubble_d;
        end
    end

    // Entry write on accepted push.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= wr_entry_c;
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

    localparam int unsigned AW = 32;
    localparam int unsigned IW = 32;
    localparam logic [IW-1:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [IW-1:0] inst;
        logic [AW-1:0] pc;
        logic [AW-1:0] pc4;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [IW-1:0] in_inst;
    logic [AW-1:0] in_pc;
    logic [AW-1:0] in_pc_plus4;
    logic          in_ready;
    logic          out_valid;
    logic [IW-1:0] out_inst;
    logic [AW-1:0] out_pc;
    logic [AW-1:0] out_pc_plus4;
    logic          out_ready;
    logic          flush;
    logic [1:0]    count;
    logic [15:0]   bubble_cnt;

    int unsigned checks = 0;
    int unsigned errors = 0;
    exp_t        sb[$];
    logic [15:0] exp_bub = '0;

    if_id_queue #(.AddrSize(AW), .Inst_Size(IW), .NOP_INST(NOP)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_inst     (in_inst),
        .in_pc       (in_pc),
        .in_pc_plus4 (in_pc_plus4),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .out_pc_plus4(out_pc_plus4),
        .out_ready   (out_ready),
        .flush       (flush),
        .count       (count),
        .bubble_cnt  (bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] pc, input logic ordy, input logic fl);
        in_valid    = v;
        in_pc       = pc;
        in_pc_plus4 = pc + AW'(4);
        in_inst     = (pc == '0) ? 32'h0050_0093 : $urandom();
        out_ready   = ordy;
        flush       = fl;
    endtask

    // Called with clk low: compare outputs to the model, advance model and clock.
    task automatic cycle();
        exp_t e;
        logic push, pop;
        int   sz;
        sz = sb.size();
        check_eq("count", 64'(count), 64'(sz));
        check_eq("in_ready", 64'(in_ready), 64'(sz < 2));
        check_eq("out_valid", 64'(out_valid), 64'(sz != 0));
        check_eq("bubble_cnt", 64'(bubble_cnt), 64'(exp_bub));
        if (sz != 0) begin
            check_eq("head_inst", 64'(out_inst), 64'(sb[0].inst));
            check_eq("head_pc", 64'(out_pc), 64'(sb[0].pc));
            check_eq("head_pc4", 64'(out_pc_plus4), 64'(sb[0].pc4));
        end else begin
            check_eq("empty_inst", 64'(out_inst), 64'(NOP));
            check_eq("empty_pc", 64'(out_pc), 64'd0);
            check_eq("empty_pc4", 64'(out_pc_plus4), 64'd0);
        end
        push = in_valid && (sz < 2) && !flush;
        pop  = (sz != 0) && out_ready && !flush;
        if (out_ready && (sz == 0) && !flush && (exp_bub != 16'hFFFF)) exp_bub++;
        e.inst = in_inst;
        e.pc   = in_pc;
        e.pc4  = in_pc_plus4;
        if (flush) sb.delete();
        else begin
            if (pop)  void'(sb.pop_front());
            if (push) sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Assert reset between edges and confirm outputs change without a clock.
    task automatic async_reset();
        #1 reset = 1'b0;
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_inst", 64'(out_inst), 64'(NOP));
        check_eq("rst_out_pc", 64'(out_pc), 64'd0);
        check_eq("rst_out_pc4", 64'(out_pc_plus4), 64'd0);
        check_eq("rst_count", 64'(count), 64'd0);
        check_eq("rst_bubble", 64'(bubble_cnt), 64'd0);
        sb.delete();
        exp_bub = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check_eq("init_count", 64'(count), 64'd0);
        check_eq("init_in_ready", 64'(in_ready), 64'd1);
        check_eq("init_out_inst", 64'(out_inst), 64'(NOP));
        reset = 1'b1;

        // Single push, decode stalled: visible one cycle later.
        drive(1'b1, 32'd0, 1'b0, 1'b0); cycle();
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        check_eq("first_inst", 64'(out_inst), 64'h0050_0093);
        check_eq("first_pc4", 64'(out_pc_plus4), 64'd4);
        cycle();
        drive(1'b0, 32'd0, 1'b1, 1'b0); cycle();

        // Three back-to-back pushes with decode stalled; third is refused.
        drive(1'b1, 32'd0, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'd4, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'd8, 1'b0, 1'b0);
        check_eq("full_in_ready", 64'(in_ready), 64'd0);
        cycle();
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        check_eq("order_pc0", 64'(out_pc), 64'd0);
        cycle();
        check_eq("order_pc4", 64'(out_pc), 64'd4);
        cycle();

        // Full with simultaneous push and pop: pop only.
        drive(1'b1, 32'h10, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'h14, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'h18, 1'b1, 1'b0); cycle();
        check_eq("full_pop_count", 64'(count), 64'd1);

        // Full queue flushed while fetch is pushing.
        drive(1'b1, 32'h1c, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'h20, 1'b0, 1'b1); cycle();
        check_eq("flush_count", 64'(count), 64'd0);
        check_eq("flush_inst", 64'(out_inst), 64'(NOP));

        // Steady state at count 1 with push and pop every cycle.
        drive(1'b1, 32'h100, 1'b0, 1'b0); cycle();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 32'h100 + AW'(4 * i), 1'b1, 1'b0);
            cycle();
        end
        check_eq("stream_count", 64'(count), 64'd1);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 15) == 0));
            cycle();
        end

        // Reset with a full queue: nothing survives, then normal operation.
        drive(1'b1, 32'h200, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'h204, 1'b0, 1'b0); cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        async_reset();
        cycle();
        drive(1'b1, 32'h300, 1'b0, 1'b0); cycle();
        drive(1'b0, 32'h0, 1'b1, 1'b0); cycle();
        cycle();

        // Long starvation: bubble counter saturates, then reset mid-stream.
        drive(1'b0, 32'h0, 1'b1, 1'b1); cycle();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 70000; i++) cycle();
        check_eq("bubble_sat", 64'(bubble_cnt), 64'hFFFF);
        async_reset();
        cycle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
